// File: rtl/ipsl_pcie_dma_tlp_rx_demux.sv
`timescale 1ns/1ps
// ipsl_pcie_dma_tlp_rx_demux
// Steers TLPs arriving from the PCIe core RX AXIS port to one of two DMA-side
// AXIS masters: requests (MRd/MWr) to master0, completions (Cpl/CplD) to
// master1. Every other TLP type is absorbed and counted in a saturating
// drop counter. Classification happens on the first beat only; the whole TLP
// follows that decision.
//
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   i_pcie_axis_master_*        RX beat stream from the PCIe core (trdy is comb)
//   o_dma_axis_master0_*        request stream, one-entry output register
//   o_dma_axis_master1_*        completion stream, one-entry output register
//   o_rx_drop_cnt               saturating count of dropped TLPs
//   o_rx_drop_pulse             one-cycle pulse per dropped TLP first beat
module ipsl_pcie_dma_tlp_rx_demux #(
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pcie_axis_master_tvld,
  output logic                  o_pcie_axis_master_trdy,
  input  logic [127:0]          i_pcie_axis_master_tdata,
  input  logic                  i_pcie_axis_master_tlast,
  input  logic                  i_pcie_axis_master_tuser,

  input  logic                  i_dma_axis_master0_trdy,
  output logic                  o_dma_axis_master0_tvld,
  output logic [127:0]          o_dma_axis_master0_tdata,
  output logic                  o_dma_axis_master0_tlast,
  output logic                  o_dma_axis_master0_tuser,

  input  logic                  i_dma_axis_master1_trdy,
  output logic                  o_dma_axis_master1_tvld,
  output logic [127:0]          o_dma_axis_master1_tdata,
  output logic                  o_dma_axis_master1_tlast,
  output logic                  o_dma_axis_master1_tuser,

  output logic [DROP_CNT_W-1:0] o_rx_drop_cnt,
  output logic                  o_rx_drop_pulse
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned FT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD_REQ,
    ST_FWD_CPL,
    ST_DROP
  } state_t;

  typedef enum logic [1:0] {
    CLS_REQ,
    CLS_CPL,
    CLS_DROP
  } cls_t;

  state_t            state, state_nxt;
  cls_t              cls_c;
  logic [FT_W-1:0]   fmt_type_c;
  logic              port0_free_c;
  logic              port1_free_c;
  logic              rdy_c;
  logic              load0_c;
  logic              load1_c;
  logic              drop_first_c;

  // Fmt/Type byte of header DW0; only meaningful while in IDLE
  assign fmt_type_c = i_pcie_axis_master_tdata[31:24];

  // TLP class decode
  always_comb begin
    cls_c = CLS_DROP;
    case (fmt_type_c)
      8'h00, 8'h20, 8'h40, 8'h60: cls_c = CLS_REQ;
      8'h0A, 8'h4A:               cls_c = CLS_CPL;
      default:                    cls_c = CLS_DROP;
    endcase
  end

  // An output register can take a beat when empty or draining this cycle
  assign port0_free_c = !o_dma_axis_master0_tvld || i_dma_axis_master0_trdy;
  assign port1_free_c = !o_dma_axis_master1_tvld || i_dma_axis_master1_trdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, input ready and per-port load strobes
  always_comb begin
    state_nxt    = state;
    rdy_c        = 1'b0;
    load0_c      = 1'b0;
    load1_c      = 1'b0;
    drop_first_c = 1'b0;
    case (state)
      ST_IDLE: begin
        case (cls_c)
          CLS_REQ: rdy_c = port0_free_c;
          CLS_CPL: rdy_c = port1_free_c;
          default: rdy_c = 1'b1;
        endcase
        if (i_pcie_axis_master_tvld && rdy_c) begin
          load0_c      = (cls_c == CLS_REQ);
          load1_c      = (cls_c == CLS_CPL);
          drop_first_c = (cls_c == CLS_DROP);
          if (!i_pcie_axis_master_tlast) begin
            case (cls_c)
              CLS_REQ: state_nxt = ST_FWD_REQ;
              CLS_CPL: state_nxt = ST_FWD_CPL;
              default: state_nxt = ST_DROP;
            endcase
          end
        end
      end
      ST_FWD_REQ: begin
        rdy_c = port0_free_c;
        if (i_pcie_axis_master_tvld && rdy_c) begin
          load0_c = 1'b1;
          if (i_pcie_axis_master_tlast) state_nxt = ST_IDLE;
        end
      end
      ST_FWD_CPL: begin
        rdy_c = port1_free_c;
        if (i_pcie_axis_master_tvld && rdy_c) begin
          load1_c = 1'b1;
          if (i_pcie_axis_master_tlast) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        rdy_c = 1'b1;
        if (i_pcie_axis_master_tvld && i_pcie_axis_master_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_pcie_axis_master_trdy = rdy_c;

  // Request output register; a new load wins over a drain in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dma_axis_master0_tvld  <= 1'b0;
      o_dma_axis_master0_tdata <= DATA_W'(0);
      o_dma_axis_master0_tlast <= 1'b0;
      o_dma_axis_master0_tuser <= 1'b0;
    end else if (load0_c) begin
      o_dma_axis_master0_tvld  <= 1'b1;
      o_dma_axis_master0_tdata <= i_pcie_axis_master_tdata;
      o_dma_axis_master0_tlast <= i_pcie_axis_master_tlast;
      o_dma_axis_master0_tuser <= i_pcie_axis_master_tuser;
    end else if (i_dma_axis_master0_trdy) begin
      o_dma_axis_master0_tvld  <= 1'b0;
    end
  end

  // Completion output register
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dma_axis_master1_tvld  <= 1'b0;
      o_dma_axis_master1_tdata <= DATA_W'(0);
      o_dma_axis_master1_tlast <= 1'b0;
      o_dma_axis_master1_tuser <= 1'b0;
    end else if (load1_c) begin
      o_dma_axis_master1_tvld  <= 1'b1;
      o_dma_axis_master1_tdata <= i_pcie_axis_master_tdata;
      o_dma_axis_master1_tlast <= i_pcie_axis_master_tlast;
      o_dma_axis_master1_tuser <= i_pcie_axis_master_tuser;
    end else if (i_dma_axis_master1_trdy) begin
      o_dma_axis_master1_tvld  <= 1'b0;
    end
  end

  // Saturating drop counter and first-beat pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_drop_cnt   <= DROP_CNT_W'(0);
      o_rx_drop_pulse <= 1'b0;
    end else begin
      o_rx_drop_pulse <= drop_first_c;
      if (drop_first_c && (o_rx_drop_cnt != {DROP_CNT_W{1'b1}})) begin
        o_rx_drop_cnt <= o_rx_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_dma_tlp_rx_demux.sv
`timescale 1ns/1ps
// Testbench for ipsl_pcie_dma_tlp_rx_demux: directed scenario tasks plus a
// randomized traffic phase, all checked by a queue-based reference model.
module tb_ipsl_pcie_dma_tlp_rx_demux;

  logic         clk;
  logic         rst;
  logic         i_pcie_axis_master_tvld;
  logic         o_pcie_axis_master_trdy;
  logic [127:0] i_pcie_axis_master_tdata;
  logic         i_pcie_axis_master_tlast;
  logic         i_pcie_axis_master_tuser;
  logic         i_dma_axis_master0_trdy;
  logic         o_dma_axis_master0_tvld;
  logic [127:0] o_dma_axis_master0_tdata;
  logic         o_dma_axis_master0_tlast;
  logic         o_dma_axis_master0_tuser;
  logic         i_dma_axis_master1_trdy;
  logic         o_dma_axis_master1_tvld;
  logic [127:0] o_dma_axis_master1_tdata;
  logic         o_dma_axis_master1_tlast;
  logic         o_dma_axis_master1_tuser;
  logic [15:0]  o_rx_drop_cnt;
  logic         o_rx_drop_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  ipsl_pcie_dma_tlp_rx_demux #(.DROP_CNT_W(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_pcie_axis_master_tvld  (i_pcie_axis_master_tvld),
    .o_pcie_axis_master_trdy  (o_pcie_axis_master_trdy),
    .i_pcie_axis_master_tdata (i_pcie_axis_master_tdata),
    .i_pcie_axis_master_tlast (i_pcie_axis_master_tlast),
    .i_pcie_axis_master_tuser (i_pcie_axis_master_tuser),
    .i_dma_axis_master0_trdy  (i_dma_axis_master0_trdy),
    .o_dma_axis_master0_tvld  (o_dma_axis_master0_tvld),
    .o_dma_axis_master0_tdata (o_dma_axis_master0_tdata),
    .o_dma_axis_master0_tlast (o_dma_axis_master0_tlast),
    .o_dma_axis_master0_tuser (o_dma_axis_master0_tuser),
    .i_dma_axis_master1_trdy  (i_dma_axis_master1_trdy),
    .o_dma_axis_master1_tvld  (o_dma_axis_master1_tvld),
    .o_dma_axis_master1_tdata (o_dma_axis_master1_tdata),
    .o_dma_axis_master1_tlast (o_dma_axis_master1_tlast),
    .o_dma_axis_master1_tuser (o_dma_axis_master1_tuser),
    .o_rx_drop_cnt            (o_rx_drop_cnt),
    .o_rx_drop_pulse          (o_rx_drop_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  logic [7:0] ft_tab [10] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h0A,
                              8'h4A, 8'h04, 8'h44, 8'h34, 8'h01};

  logic [129:0] q0 [$];
  logic [129:0] q1 [$];
  bit           in_tlp     = 1'b0;
  int           cur_cls    = 0;
  bit           pend_pulse = 1'b0;
  logic [15:0]  model_cnt  = 16'h0;
  bit           rand_sink  = 1'b0;

  // 0 = request, 1 = completion, 2 = dropped
  function automatic int cls_of(input logic [7:0] b);
    case (b)
      8'h00, 8'h20, 8'h40, 8'h60: return 0;
      8'h0A, 8'h4A:               return 1;
      default:                    return 2;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] hdr(input logic [31:0] dw0);
    logic [127:0] r;
    r = rnd128();
    r[31:0] = dw0;
    return r;
  endfunction

  // Scoreboard: sampled on the falling edge, describing the next rising edge
  always @(negedge clk) begin
    logic [129:0] e;
    logic [129:0] got;
    int c;
    if (pend_pulse && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    n_checks++;
    if (o_rx_drop_pulse !== pend_pulse) begin
      n_fail++;
      $display("FAIL drop_pulse t=%0t: got %b want %b", $time, o_rx_drop_pulse, pend_pulse);
    end
    n_checks++;
    if (o_rx_drop_cnt !== model_cnt) begin
      n_fail++;
      $display("FAIL drop_cnt t=%0t: got %h want %h", $time, o_rx_drop_cnt, model_cnt);
    end
    if (!rst && o_dma_axis_master0_tvld === 1'b1 && i_dma_axis_master0_trdy) begin
      n_checks++;
      got = {o_dma_axis_master0_tuser, o_dma_axis_master0_tlast, o_dma_axis_master0_tdata};
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL port0_unexpected t=%0t: got %h want no beat", $time, got);
      end else begin
        e = q0.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL port0_beat t=%0t: got %h want %h", $time, got, e);
        end
      end
    end
    if (!rst && o_dma_axis_master1_tvld === 1'b1 && i_dma_axis_master1_trdy) begin
      n_checks++;
      got = {o_dma_axis_master1_tuser, o_dma_axis_master1_tlast, o_dma_axis_master1_tdata};
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL port1_unexpected t=%0t: got %h want no beat", $time, got);
      end else begin
        e = q1.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL port1_beat t=%0t: got %h want %h", $time, got, e);
        end
      end
    end
    pend_pulse = 1'b0;
    if (rst) begin
      q0.delete();
      q1.delete();
      in_tlp    = 1'b0;
      model_cnt = 16'h0;
    end else if (i_pcie_axis_master_tvld && o_pcie_axis_master_trdy === 1'b1) begin
      if (!in_tlp) begin
        cur_cls = cls_of(i_pcie_axis_master_tdata[31:24]);
        if (cur_cls == 2) pend_pulse = 1'b1;
      end
      c = cur_cls;
      e = {i_pcie_axis_master_tuser, i_pcie_axis_master_tlast, i_pcie_axis_master_tdata};
      if (c == 0) q0.push_back(e);
      else if (c == 1) q1.push_back(e);
      in_tlp = !i_pcie_axis_master_tlast;
    end
  end

  // Random sink back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_sink) begin
        i_dma_axis_master0_trdy = ($urandom_range(0, 3) != 0);
        i_dma_axis_master1_trdy = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_beat(input logic [127:0] d, input logic last, input logic user);
    int waited;
    waited = 0;
    i_pcie_axis_master_tvld  = 1'b1;
    i_pcie_axis_master_tdata = d;
    i_pcie_axis_master_tlast = last;
    i_pcie_axis_master_tuser = user;
    @(negedge clk);
    while (o_pcie_axis_master_trdy !== 1'b1) begin
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout t=%0t: input ready %b want 1 within 200 cycles",
                 $time, o_pcie_axis_master_trdy);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_pcie_axis_master_tvld = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master0_tvld, o_dma_axis_master1_tvld} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_tvld: got %b want 00", {o_dma_axis_master0_tvld, o_dma_axis_master1_tvld});
    end
    n_checks++;
    if ({o_dma_axis_master0_tdata, o_dma_axis_master1_tdata, o_dma_axis_master0_tlast,
         o_dma_axis_master1_tlast, o_dma_axis_master0_tuser, o_dma_axis_master1_tuser} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h %h want 0", o_dma_axis_master0_tdata, o_dma_axis_master1_tdata);
    end
    n_checks++;
    if (o_pcie_axis_master_trdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_trdy: got %b want 1", o_pcie_axis_master_trdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_pcie_axis_master_trdy !== 1'b1 || o_rx_drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got trdy=%b cnt=%h want 1/0000", o_pcie_axis_master_trdy, o_rx_drop_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mwr();
    logic [127:0] b [3];
    b[0] = hdr(32'h60000004);
    b[1] = rnd128();
    b[2] = rnd128();
    i_dma_axis_master0_trdy = 1'b1;
    i_dma_axis_master1_trdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_pcie_axis_master_tvld  = 1'b1;
      i_pcie_axis_master_tdata = b[i];
      i_pcie_axis_master_tlast = (i == 2);
      i_pcie_axis_master_tuser = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_pcie_axis_master_trdy !== 1'b1) begin
        n_fail++;
        $display("FAIL mwr_in_trdy beat %0d: got %b want 1", i, o_pcie_axis_master_trdy);
      end
      if (i > 0) begin
        n_checks++;
        if ({o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_dma_axis_master0_tlast} !==
            {1'b1, b[i-1], 1'b0}) begin
          n_fail++;
          $display("FAIL mwr_out beat %0d: got v=%b d=%h l=%b want 1/%h/0", i - 1,
                   o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_dma_axis_master0_tlast, b[i-1]);
        end
      end
      n_checks++;
      if (o_dma_axis_master1_tvld !== 1'b0) begin
        n_fail++;
        $display("FAIL mwr_port1_idle: got %b want 0", o_dma_axis_master1_tvld);
      end
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_dma_axis_master0_tlast} !== {1'b1, b[2], 1'b1}) begin
      n_fail++;
      $display("FAIL mwr_last: got v=%b d=%h l=%b want 1/%h/1", o_dma_axis_master0_tvld,
               o_dma_axis_master0_tdata, o_dma_axis_master0_tlast, b[2]);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (o_dma_axis_master0_tvld !== 1'b0) begin
      n_fail++;
      $display("FAIL mwr_drained: got %b want 0", o_dma_axis_master0_tvld);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cpl_stall();
    logic [127:0] c [3];
    c[0] = hdr(32'h4A000008);
    c[1] = rnd128();
    c[2] = rnd128();
    i_dma_axis_master1_trdy = 1'b1;
    send_beat(c[0], 1'b0, 1'b1);
    i_dma_axis_master1_trdy = 1'b0;
    i_pcie_axis_master_tdata = c[1];
    i_pcie_axis_master_tlast = 1'b0;
    i_pcie_axis_master_tuser = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_pcie_axis_master_trdy !== 1'b0) begin
        n_fail++;
        $display("FAIL cpl_stall_trdy cycle %0d: got %b want 0", k, o_pcie_axis_master_trdy);
      end
      n_checks++;
      if ({o_dma_axis_master1_tvld, o_dma_axis_master1_tdata} !== {1'b1, c[0]}) begin
        n_fail++;
        $display("FAIL cpl_stall_hold cycle %0d: got v=%b d=%h want 1/%h", k,
                 o_dma_axis_master1_tvld, o_dma_axis_master1_tdata, c[0]);
      end
      @(posedge clk);
      #1;
    end
    i_dma_axis_master1_trdy = 1'b1;
    send_beat(c[1], 1'b0, 1'b0);
    send_beat(c[2], 1'b1, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_drop();
    logic [127:0] m0, m1, rd;
    m0 = hdr(32'h34000000);
    m1 = rnd128();
    rd = hdr(32'h00000001);
    i_dma_axis_master0_trdy = 1'b1;
    i_dma_axis_master1_trdy = 1'b1;
    send_beat(m0, 1'b0, 1'b0);
    i_pcie_axis_master_tdata = m1;
    i_pcie_axis_master_tlast = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_rx_drop_pulse, o_rx_drop_cnt, o_pcie_axis_master_trdy} !== {1'b1, 16'h0001, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_first: got pulse=%b cnt=%h trdy=%b want 1/0001/1",
               o_rx_drop_pulse, o_rx_drop_cnt, o_pcie_axis_master_trdy);
    end
    @(posedge clk);
    #1;
    i_pcie_axis_master_tdata = rd;
    i_pcie_axis_master_tlast = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_rx_drop_pulse, o_dma_axis_master0_tvld, o_dma_axis_master1_tvld} !== 3'b000) begin
      n_fail++;
      $display("FAIL drop_absorbed: got pulse=%b v0=%b v1=%b want 000",
               o_rx_drop_pulse, o_dma_axis_master0_tvld, o_dma_axis_master1_tvld);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_dma_axis_master0_tlast, o_rx_drop_cnt} !==
        {1'b1, rd, 1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL drop_then_mrd: got v=%b d=%h cnt=%h want 1/%h/0001",
               o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_rx_drop_cnt, rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] ca, cb, rd;
    ca = hdr(32'h0A000000);
    cb = hdr(32'h0A000000);
    rd = hdr(32'h00000001);
    i_dma_axis_master0_trdy = 1'b1;
    i_dma_axis_master1_trdy = 1'b0;
    send_beat(ca, 1'b1, 1'b0);
    i_pcie_axis_master_tdata = cb;
    i_pcie_axis_master_tlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({o_pcie_axis_master_trdy, o_dma_axis_master0_tvld} !== 2'b00) begin
        n_fail++;
        $display("FAIL hol_blocked cycle %0d: got trdy=%b v0=%b want 00", k,
                 o_pcie_axis_master_trdy, o_dma_axis_master0_tvld);
      end
      n_checks++;
      if ({o_dma_axis_master1_tvld, o_dma_axis_master1_tdata} !== {1'b1, ca}) begin
        n_fail++;
        $display("FAIL hol_cpl_hold cycle %0d: got v=%b d=%h want 1/%h", k,
                 o_dma_axis_master1_tvld, o_dma_axis_master1_tdata, ca);
      end
      @(posedge clk);
      #1;
    end
    i_dma_axis_master1_trdy = 1'b1;
    send_beat(cb, 1'b1, 1'b0);
    send_beat(rd, 1'b1, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [127:0] d;
    int len;
    logic [7:0] b;
    rand_sink = 1'b1;
    for (int t = 0; t < 400; t++) begin
      len = $urandom_range(1, 4);
      b   = ft_tab[$urandom_range(0, 9)];
      for (int k = 0; k < len; k++) begin
        if (k == 0) d = hdr({b, 24'($urandom)});
        else begin
          d = rnd128();
          if ($urandom_range(0, 1) == 1) d[31:24] = ft_tab[$urandom_range(0, 9)];
        end
        send_beat(d, (k == len - 1), 1'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    rand_sink = 1'b0;
    #2;
    i_dma_axis_master0_trdy = 1'b1;
    i_dma_axis_master1_trdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d/%0d beats outstanding want 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65535; i++) send_beat(hdr(32'h44000001), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_rx_drop_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %h want ffff", o_rx_drop_cnt);
    end
    @(posedge clk);
    #1;
    send_beat(hdr(32'h34000000), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    n_checks++;
    if ({o_rx_drop_pulse, o_rx_drop_cnt} !== {1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL sat_hold: got pulse=%b cnt=%h want 1/ffff", o_rx_drop_pulse, o_rx_drop_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] c0, c1;
    i_dma_axis_master0_trdy = 1'b1;
    i_dma_axis_master1_trdy = 1'b1;
    send_beat(hdr(32'h60000004), 1'b0, 1'b0);
    send_beat(rnd128(), 1'b0, 1'b1);
    i_pcie_axis_master_tdata = rnd128();
    i_pcie_axis_master_tlast = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master0_tvld, o_dma_axis_master0_tdata, o_dma_axis_master0_tlast,
         o_dma_axis_master1_tvld, o_rx_drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got v0=%b d0=%h v1=%b cnt=%h want all 0", o_dma_axis_master0_tvld,
               o_dma_axis_master0_tdata, o_dma_axis_master1_tvld, o_rx_drop_cnt);
    end
    @(posedge clk);
    #1;
    c0 = hdr(32'h4A000008);
    c1 = hdr(32'h60000004);
    send_beat(c0, 1'b0, 1'b0);
    i_pcie_axis_master_tdata = c1;
    i_pcie_axis_master_tlast = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master1_tvld, o_dma_axis_master1_tdata, o_dma_axis_master0_tvld} !== {1'b1, c0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_cpld: got v1=%b d1=%h v0=%b want 1/%h/0", o_dma_axis_master1_tvld,
               o_dma_axis_master1_tdata, o_dma_axis_master0_tvld, c0);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    n_checks++;
    if ({o_dma_axis_master1_tvld, o_dma_axis_master1_tdata, o_dma_axis_master1_tlast, o_dma_axis_master0_tvld} !==
        {1'b1, c1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_cpld_tail: got v1=%b d1=%h l1=%b v0=%b want 1/%h/1/0", o_dma_axis_master1_tvld,
               o_dma_axis_master1_tdata, o_dma_axis_master1_tlast, o_dma_axis_master0_tvld, c1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                      = 1'b1;
    i_pcie_axis_master_tvld  = 1'b0;
    i_pcie_axis_master_tdata = '0;
    i_pcie_axis_master_tlast = 1'b0;
    i_pcie_axis_master_tuser = 1'b0;
    i_dma_axis_master0_trdy  = 1'b1;
    i_dma_axis_master1_trdy  = 1'b1;
    test_reset();
    test_mwr();
    test_cpl_stall();
    test_drop();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d/%0d beats outstanding want 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
